// File: rtl/imem_fetch_port.sv
// Instruction memory fetch port.
//
// Word-organised instruction store with a run-time loader write port and a
// valid/ready fetch interface. A request is accepted in IDLE, optionally
// waits WAIT_STATES cycles, then presents a registered response in RESP
// until the consumer takes it. Misaligned or out-of-range addresses return
// an error response carrying NOP_WORD, with the same latency as a good read.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  fetch request valid
//   req_ready  request can be accepted this cycle
//   req_addr   byte address of the instruction
//   rsp_valid  response valid
//   rsp_ready  consumer accepts the response
//   rsp_instr  fetched instruction (NOP_WORD on error / after reset)
//   rsp_err    response is an error
//   ld_en      loader write strobe
//   ld_addr    loader word index
//   ld_data    loader word
//   busy       a transaction is in flight
module imem_fetch_port #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data,
  output logic                           busy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic [31:0]     rsp_instr_q, rsp_instr_d;
  logic            rsp_err_q, rsp_err_d;

  // Storage: not reset, so loaded code survives a core reset.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Request decode. Any set bit above the in-range index is an error; the
  // address is never wrapped onto the array.
  logic [IdxW-1:0] req_idx;
  logic            req_misalign;
  logic            req_range;
  logic            req_err;

  assign req_idx      = req_addr[IdxW+1:2];
  assign req_misalign = |req_addr[1:0];
  assign req_range    = |(req_addr >> (IdxW + 2));
  assign req_err      = req_misalign | req_range;

  // Capture controls for the response registers on entry to RESP.
  logic            cap_en;
  logic [IdxW-1:0] cap_idx;
  logic            cap_err;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cap_en    = 1'b0;
    cap_idx   = idx_q;
    cap_err   = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = ~ld_en;
        if (req_valid && !ld_en) begin
          idx_d = req_idx;
          err_d = req_err;
          if (WAIT_STATES == 0) begin
            // Zero wait states: capture straight from the live request.
            state_d = StResp;
            cap_en  = 1'b1;
            cap_idx = req_idx;
            cap_err = req_err;
          end else begin
            state_d = StWait;
            wcnt_d  = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (wcnt_q == 4'd0) begin
          state_d = StResp;
          cap_en  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The array is read combinationally and registered on the capture edge,
  // so a loader write on that same edge is not seen (old data returned).
  always_comb begin
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    if (cap_en) begin
      rsp_instr_d = cap_err ? NOP_WORD : mem[cap_idx];
      rsp_err_d   = cap_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wcnt_q      <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_instr_q <= NOP_WORD;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Scoreboard bench for imem_fetch_port: three instances with WAIT_STATES of
// 1 (main), 0 and 3. Drivers push expected responses; a negedge monitor
// checks latency, hold stability under backpressure and response contents.
module tb_imem_fetch_port;

  localparam logic [31:0] Nop = 32'hE1A0_0000;
  localparam int NDut = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid [NDut];
  logic        req_ready [NDut];
  logic [31:0] req_addr  [NDut];
  logic        rsp_valid [NDut];
  logic        rsp_ready [NDut];
  logic [31:0] rsp_instr [NDut];
  logic        rsp_err   [NDut];
  logic        ld_en     [NDut];
  logic [7:0]  ld_addr   [NDut];
  logic [31:0] ld_data   [NDut];
  logic        busy      [NDut];

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    imem_fetch_port #(
      .ADDR_W      (32),
      .DEPTH_WORDS (256),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .NOP_WORD    (Nop)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_instr (rsp_instr[g]),
      .rsp_err   (rsp_err[g]),
      .ld_en     (ld_en[g]),
      .ld_addr   (ld_addr[g]),
      .ld_data   (ld_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int total = 0;
  int bad = 0;

  exp_t sb_q [NDut][$];
  int   acc_q [NDut][$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor
  logic        vprev      [NDut];
  logic [31:0] hold_instr [NDut];
  logic        hold_err   [NDut];

  initial begin
    for (int d = 0; d < NDut; d++) vprev[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDut; d++) begin
        if (!rst) begin
          vprev[d] = 1'b0;
        end else begin
          if (req_valid[d] && req_ready[d]) acc_q[d].push_back(cyc + 1);
          if (rsp_valid[d] && !vprev[d]) begin
            if (acc_q[d].size() == 0) begin
              fail_now($sformatf("dut%0d unexpected_rsp", d));
            end else begin
              int a;
              a = acc_q[d].pop_front();
              chk($sformatf("dut%0d latency_cycle", d), 32'(cyc), 32'(a + ws_of(d)));
            end
            hold_instr[d] = rsp_instr[d];
            hold_err[d]   = rsp_err[d];
          end else if (rsp_valid[d]) begin
            chk($sformatf("dut%0d hold_instr", d), rsp_instr[d], hold_instr[d]);
            chk($sformatf("dut%0d hold_err", d), 32'(rsp_err[d]), 32'(hold_err[d]));
          end
          if (rsp_valid[d] && rsp_ready[d]) begin
            if (sb_q[d].size() == 0) begin
              fail_now($sformatf("dut%0d rsp_without_expect", d));
            end else begin
              exp_t e;
              e = sb_q[d].pop_front();
              chk($sformatf("dut%0d rsp_instr", d), rsp_instr[d], e.instr);
              chk($sformatf("dut%0d rsp_err", d), 32'(rsp_err[d]), 32'(e.err));
            end
          end
          vprev[d] = rsp_valid[d] && !rsp_ready[d];
        end
      end
    end
  end

  // Driver tasks; each starts and ends 1 ns after a rising edge.
  task automatic load(input int d, input logic [7:0] a, input logic [31:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    @(posedge clk); #1;
    ld_en[d] = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] ei,
                       input logic ee, output int acc);
    exp_t e;
    e.instr = ei;
    e.err   = ee;
    sb_q[d].push_back(e);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) fail_now($sformatf("dut%0d accept_timeout", d));
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 50; i++) begin
      if (sb_q[d].size() == 0) break;
      @(negedge clk);
    end
    if (sb_q[d].size() != 0) fail_now($sformatf("dut%0d drain_timeout", d));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int a0, a1, ax;

  initial begin
    rst = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = '0;
      rsp_ready[d] = 1'b1;
      ld_en[d]     = 1'b0;
      ld_addr[d]   = '0;
      ld_data[d]   = '0;
    end
    #12;
    chk("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("reset rsp_instr", rsp_instr[0], Nop);
    rst = 1'b1;
    #1;
    chk("reset req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;

    load(0, 8'd0, 32'hE3A0_0015);
    load(0, 8'd1, 32'hE3A0_1101);
    load(0, 8'd2, 32'h1111_2222);
    load(0, 8'd5, 32'hAAAA_5555);

    // Back-to-back reads, accepts spaced WAIT_STATES+2 apart.
    fetch(0, 32'd0, 32'hE3A0_0015, 1'b0, a0);
    fetch(0, 32'd4, 32'hE3A0_1101, 1'b0, a1);
    chk("accept_spacing", 32'(a1 - a0), 32'd3);
    drain(0);

    // Backpressure.
    rsp_ready[0] = 1'b0;
    fetch(0, 32'd8, 32'h1111_2222, 1'b0, ax);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs req_ready", 32'(req_ready[0]), 32'd1);
    chk("post_hs rsp_valid", 32'(rsp_valid[0]), 32'd0);
    drain(0);

    // Error responses: misaligned and out of range.
    fetch(0, 32'd2, Nop, 1'b1, ax);
    drain(0);
    fetch(0, 32'd1024, Nop, 1'b1, ax);
    drain(0);

    // Loader write on the RESP-entry edge of a read of the same word.
    fetch(0, 32'd20, 32'hAAAA_5555, 1'b0, ax);
    load(0, 8'd5, 32'h5555_AAAA);
    drain(0);
    fetch(0, 32'd20, 32'h5555_AAAA, 1'b0, ax);
    drain(0);

    // Loader strobe in IDLE blocks acceptance.
    ld_en[0]     = 1'b1;
    ld_addr[0]   = 8'd6;
    ld_data[0]   = 32'h0606_0606;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'd0;
    @(negedge clk);
    chk("ld_en req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    ld_en[0]     = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("ld_en no_accept busy", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;

    // Latency sweep on the WAIT_STATES=0 and =3 instances.
    for (int d = 1; d < NDut; d++) begin
      load(d, 8'd2, 32'hCAFE_0008 + 32'(d));
      fetch(d, 32'd8, 32'hCAFE_0008 + 32'(d), 1'b0, ax);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk($sformatf("dut%0d busy", d), 32'(busy[d]), 32'd1);
        if (rsp_valid[d]) break;
      end
      @(posedge clk); #1;
      drain(d);
    end

    // Asynchronous reset in the middle of WAIT.
    fetch(0, 32'd0, 32'hE3A0_0015, 1'b0, ax);
    #3;
    rst = 1'b0;
    sb_q[0].delete();
    acc_q[0].delete();
    #1;
    chk("midwait rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midwait rsp_instr", rsp_instr[0], Nop);
    chk("midwait busy", 32'(busy[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("release req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    fetch(0, 32'd0, 32'hE3A0_0015, 1'b0, ax);
    drain(0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised successor to the fixed-content instruction memory. Word-organised instruction store with a run-time loader write port.
- Provides a valid/ready fetch request channel and a valid/ready response channel, with configurable access latency (wait states) and error reporting for misaligned or out-of-range addresses.
- Sits between the IF-stage PC logic and instruction storage. The IF stage stalls on `req_ready`/`rsp_valid` instead of assuming a combinational read.

Parameters:
- `ADDR_W`, default 32: width of the byte address from the fetch stage.
- `DEPTH_WORDS`, default 256: number of 32-bit instruction words stored. Must be a power of 2 and at least 2.
- `WAIT_STATES`, default 1: extra cycles between request acceptance and response. Legal range 0..15.
- `NOP_WORD`, default 32'h0: value driven on `rsp_instr` after reset and on error responses.

Ports:
- `clk`  in  1  : clock, rising edge.
- `rst`  in  1  : asynchronous, active-low reset.
- `req_valid`  in  1  : fetch request valid.
- `req_ready`  out  1  : block can accept a request this cycle.
- `req_addr`  in  ADDR_W  : byte address of the instruction, big-endian word.
- `rsp_valid`  out  1  : response valid.
- `rsp_ready`  in  1  : consumer accepts the response.
- `rsp_instr`  out  32  : fetched instruction.
- `rsp_err`  out  1  : response is an error (misaligned or out-of-range).
- `ld_en`  in  1  : loader write strobe.
- `ld_addr`  in  $clog2(DEPTH_WORDS)  : loader word index.
- `ld_data`  in  32  : loader word.
- `busy`  out  1  : a transaction is in flight (state is not IDLE).

Behaviour:
- Storage: `DEPTH_WORDS` x 32-bit array. Contents are not affected by `rst`. Word index = `req_addr[ADDR_W-1:2]`.
- Loader: when `ld_en`=1 at a clock edge, `mem[ld_addr]` <= `ld_data`, in any state. `ld_en`=1 forces `req_ready`=0 in that cycle.
- States: IDLE, WAIT, RESP. 4-bit down-counter `wcnt`.
- IDLE:
  - `req_ready` = !`ld_en`. `rsp_valid`=0.
  - On `req_valid && req_ready`: latch the address and compute `err` = (`req_addr[1:0]`!=0) || (word index >= `DEPTH_WORDS`).
  - If `WAIT_STATES`=0, go to RESP. Otherwise `wcnt` <= `WAIT_STATES`-1 and go to WAIT.
- WAIT: `req_ready`=0. If `wcnt`==0, go to RESP; otherwise `wcnt` decrements.
- Capture:
  - On every transition into RESP, `rsp_instr` <= `err` ? `NOP_WORD` : `mem[latched index]`, and `rsp_err` <= `err`.
  - The array is sampled at that edge. A loader write to the same word on the same edge is NOT visible; old data is returned.
- Latency: `rsp_valid` rises exactly `WAIT_STATES`+1 cycles after the accepting edge.
- RESP:
  - `rsp_valid`=1. `rsp_instr` and `rsp_err` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake, return to IDLE. `rsp_valid` drops the next cycle.
  - `req_ready`=0 in RESP, so there is no same-cycle re-accept. Peak throughput is one fetch per `WAIT_STATES`+2 cycles.
- Outputs hold their last values in IDLE, except that `rsp_valid`=0.
- Error responses use the same latency and handshake as good responses. An error is never dropped silently.
- `req_addr` and `req_valid` are ignored when `req_ready`=0; a request must remain asserted until accepted.
- Reset (`rst`=0, asynchronous, any state, including mid-WAIT or mid-RESP):
  - state=IDLE, `wcnt`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_instr`=`NOP_WORD`, `busy`=0.
  - Any in-flight transaction is discarded.
  - `req_ready` = !`ld_en` as soon as reset deasserts.
- Address wrap: addresses are not wrapped. Index >= `DEPTH_WORDS` is an error even if the low bits would alias.

Test Plan:
- Load and basic read, `WAIT_STATES`=1:
  - Stimulus: load `mem[0]`=32'hE3A00015, `mem[1]`=32'hE3A01101; request addr 0, then addr 4, with `rsp_ready`=1.
  - Required response: `rsp_valid` 2 cycles after each accept; `rsp_instr` = E3A00015, then E3A01101; `rsp_err`=0; accepts spaced 3 cycles apart.
- Latency sweep at `WAIT_STATES`=0 and `WAIT_STATES`=3:
  - Stimulus: request addr 8.
  - Required response: `rsp_valid` 1 cycle after accept (`WAIT_STATES`=0) and 4 cycles after accept (`WAIT_STATES`=3); `busy`=1 throughout.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles while a response is pending.
  - Required response: `rsp_valid` stays 1 and `rsp_instr` is stable; `req_ready`=0; after the handshake, `req_ready`=1 on the next cycle.
- Errors:
  - Stimulus: request addr 2; then request addr 4*`DEPTH_WORDS` (1024 for default).
  - Required response: `rsp_err`=1 and `rsp_instr`=`NOP_WORD` for both, with normal latency.
- Collision:
  - Stimulus: `ld_en` to word 5 on the RESP-entry edge of a read of addr 20; then a second read of addr 20.
  - Required response: the first read returns old data, the second returns new data. A cycle with `ld_en`=1 in IDLE gives `req_ready`=0 and no accept.
- Reset mid-WAIT:
  - Stimulus: assert `rst`=0 asynchronously between edges during WAIT.
  - Required response: immediately `rsp_valid`=0, `rsp_instr`=`NOP_WORD`, `busy`=0; after release, array contents are intact and a re-read of addr 0 returns E3A00015.
